// File: rtl/sensor_scheduler_if.sv
// rtl/sensor_scheduler_if.sv - control, sensor pad and result signals of the sensor scheduler
interface sensor_scheduler_if #(
    parameter int NUM_SENSORS = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 20
);
    logic                   enable;
    logic [NUM_SENSORS-1:0] sensor_mask;
    logic [NUM_SENSORS-1:0] echo_in;
    logic [NUM_SENSORS-1:0] trig_out;
    logic [SEL_W-1:0]       sensor_sel;
    logic                   busy;
    logic                   meas_valid;
    logic [SEL_W-1:0]       meas_sensor;
    logic [CNT_W-1:0]       meas_count;
    logic                   meas_timeout;

    // Controller / environment side: drives enable, mask and echo pads
    modport master (
        output enable, sensor_mask, echo_in,
        input  trig_out, sensor_sel, busy, meas_valid, meas_sensor, meas_count, meas_timeout
    );

    // Scheduler side
    modport slave (
        input  enable, sensor_mask, echo_in,
        output trig_out, sensor_sel, busy, meas_valid, meas_sensor, meas_count, meas_timeout
    );
endinterface

// File: rtl/sensor_scheduler.sv
// rtl/sensor_scheduler.sv - round-robin ultrasonic ping scheduler with echo width measurement
module sensor_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 20,
    parameter int TRIG_CYCLES    = 200,
    parameter int TIMEOUT_CYCLES = 760000,
    parameter int HOLDOFF_CYCLES = 20000
) (
    input logic              clk,
    input logic              reset,
    sensor_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_REPORT,
        S_HOLDOFF
    } state_t;

    // Terminal values of the shared timer for each timed state
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_RESET    = SEL_W'(NUM_SENSORS - 1);

    state_t                 state, state_next;
    logic [SEL_W-1:0]       sel, sel_next;
    logic [CNT_W-1:0]       timer, timer_next;
    logic [CNT_W-1:0]       echo_cnt, echo_cnt_next;
    logic                   seen_low, seen_low_next;
    logic [NUM_SENSORS-1:0] sync1, sync2;
    logic                   echo;

    logic                   load_result;
    logic [CNT_W-1:0]       result_count;
    logic                   result_timeout;

    logic [SEL_W-1:0]       meas_sensor_q;
    logic [CNT_W-1:0]       meas_count_q;
    logic                   meas_timeout_q;
    logic [NUM_SENSORS-1:0] trig_vec;

    // First set mask bit strictly after cur, wrapping; a lone bit selects itself again
    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] cur,
                                                    input logic [NUM_SENSORS-1:0] mask);
        logic [SEL_W-1:0] r;
        logic             found;
        int               idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_SENSORS; i++) begin
            idx = (int'(cur) + i) % NUM_SENSORS;
            if (!found && mask[idx]) begin
                r     = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign echo = sync2[sel];

    // Two-flop synchronizer on every raw echo line
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.echo_in;
            sync2 <= sync1;
        end
    end

    // State, selection, counters and held result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            sel            <= SEL_RESET;
            timer          <= '0;
            echo_cnt       <= '0;
            seen_low       <= 1'b0;
            meas_sensor_q  <= '0;
            meas_count_q   <= '0;
            meas_timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            timer    <= timer_next;
            echo_cnt <= echo_cnt_next;
            seen_low <= seen_low_next;
            if (load_result) begin
                meas_sensor_q  <= sel;
                meas_count_q   <= result_count;
                meas_timeout_q <= result_timeout;
            end
        end
    end

    // Ping sequencing: one shared timer is restarted at every timed state boundary
    always_comb begin
        state_next     = state;
        sel_next       = sel;
        timer_next     = timer;
        echo_cnt_next  = echo_cnt;
        seen_low_next  = seen_low;
        load_result    = 1'b0;
        result_count   = '0;
        result_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.enable && (|bus.sensor_mask)) begin
                    sel_next   = next_index(sel, bus.sensor_mask);
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                timer_next    = '0;
                echo_cnt_next = '0;
                seen_low_next = 1'b0;
                state_next    = S_TRIG;
            end
            S_TRIG: begin
                if (timer == TRIG_LAST) begin
                    timer_next = '0;
                    state_next = S_WAIT_ECHO;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_WAIT_ECHO: begin
                timer_next    = timer + 1'b1;
                seen_low_next = seen_low | ~echo;
                if (timer == TIMEOUT_LAST) begin
                    load_result    = 1'b1;
                    result_timeout = 1'b1;
                    state_next     = S_REPORT;
                end else if (seen_low && echo) begin
                    // The rising cycle is itself the first high cycle of the pulse
                    echo_cnt_next = CNT_W'(1);
                    state_next    = S_MEASURE;
                end
            end
            S_MEASURE: begin
                timer_next = timer + 1'b1;
                if (!echo) begin
                    load_result  = 1'b1;
                    result_count = echo_cnt;
                    state_next   = S_REPORT;
                end else if (timer == TIMEOUT_LAST) begin
                    load_result    = 1'b1;
                    result_count   = echo_cnt + 1'b1;
                    result_timeout = 1'b1;
                    state_next     = S_REPORT;
                end else begin
                    echo_cnt_next = echo_cnt + 1'b1;
                end
            end
            S_REPORT: begin
                timer_next = '0;
                state_next = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (timer == HOLDOFF_LAST) begin
                    timer_next = '0;
                    if (bus.enable && (|bus.sensor_mask)) begin
                        sel_next   = next_index(sel, bus.sensor_mask);
                        state_next = S_CLEAR;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Trigger decode straight from the state flop so reset cuts it on the next edge
    always_comb begin
        trig_vec = '0;
        if (state == S_TRIG) trig_vec[sel] = 1'b1;
    end

    assign bus.trig_out     = trig_vec;
    assign bus.sensor_sel   = sel;
    assign bus.busy         = (state != S_IDLE);
    assign bus.meas_valid   = (state == S_REPORT);
    assign bus.meas_sensor  = meas_sensor_q;
    assign bus.meas_count   = meas_count_q;
    assign bus.meas_timeout = meas_timeout_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// tb/tb_sensor_scheduler.sv - randomized self-checking bench for sensor_scheduler
module tb_sensor_scheduler;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int CW = 20;
    localparam int TC = 4;
    localparam int TO = 64;
    localparam int HO = 8;

    typedef enum int {K_NONE, K_NORMAL, K_LONG, K_STUCK} kind_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   last_sel = NS - 1;

    always #5 clk = ~clk;

    sensor_scheduler_if #(.NUM_SENSORS(NS), .SEL_W(SW), .CNT_W(CW)) bus ();

    sensor_scheduler #(
        .NUM_SENSORS(NS), .SEL_W(SW), .CNT_W(CW),
        .TRIG_CYCLES(TC), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Round-robin rule: first enabled sensor after cur, wrapping
    function automatic int rr_next(input int cur, input logic [NS-1:0] mask);
        for (int i = 1; i <= NS; i++) begin
            if (mask[(cur + i) % NS]) return (cur + i) % NS;
        end
        return cur;
    endfunction

    // Expected result of one ping; j/w are the raw echo start and width counted
    // from the first cycle after the trigger falls; two cycles of sync latency apply
    task automatic model(input kind_t kind, input int j, input int w,
                         output int cnt, output int to, output int lat);
        case (kind)
            K_NORMAL: begin cnt = w;            to = 0; lat = j + w + 3; end
            K_LONG:   begin cnt = TO - (j + 2); to = 1; lat = TO;        end
            default:  begin cnt = 0;            to = 1; lat = TO;        end
        endcase
    endtask

    task automatic do_ping(input kind_t kind, input int j, input int w, input bit check_gap,
                           input int drop_en_at, input logic [NS-1:0] next_mask);
        int  exp_s, gap, width, cnt, to, lat, idx;
        bit  got, hi;
        logic [CW-1:0] held;
        gap = 0;
        while (bus.trig_out == '0 && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        if (bus.trig_out == '0) begin
            check("trig_seen", 0, 1);
            return;
        end
        exp_s = rr_next(last_sel, bus.sensor_mask);
        if (check_gap) check("holdoff_gap", gap, HO + 1);
        if (kind != K_STUCK) bus.echo_in = '0;
        check("trig_onehot", 32'(bus.trig_out), 32'(1 << exp_s));
        check("sensor_sel", 32'(bus.sensor_sel), exp_s);
        check("busy_ping", 32'(bus.busy), 1);
        width = 0;
        while (bus.trig_out != '0 && width < 50) begin
            @(negedge clk);
            width++;
        end
        check("trig_width", width, TC);
        model(kind, j, w, cnt, to, lat);
        got = 0;
        idx = 0;
        for (int i = 0; i < 200; i++) begin
            idx = i;
            if (bus.meas_valid) begin
                got = 1;
                break;
            end
            case (kind)
                K_NORMAL: hi = (i >= j) && (i < j + w);
                K_LONG:   hi = (i >= j);
                K_STUCK:  hi = 1'b1;
                default:  hi = 1'b0;
            endcase
            bus.echo_in = (NS'($urandom) & ~NS'(1 << exp_s)) | (NS'(hi) << exp_s);
            if (i == drop_en_at) bus.enable = 1'b0;
            @(negedge clk);
        end
        check("result_seen", got, 1);
        if (got) begin
            check("latency", idx, lat);
            check("meas_sensor", 32'(bus.meas_sensor), exp_s);
            check("meas_count", 32'(bus.meas_count), cnt);
            check("meas_timeout", 32'(bus.meas_timeout), to);
        end
        held = bus.meas_count;
        bus.echo_in = '0;
        bus.sensor_mask = next_mask;
        last_sel = exp_s;
        @(negedge clk);
        check("valid_single", 32'(bus.meas_valid), 0);
        check("count_held", 32'(bus.meas_count), 32'(held));
    endtask

    initial begin
        int    wt;
        kind_t k;
        bus.enable = 1'b0;
        bus.sensor_mask = '0;
        bus.echo_in = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_trig", 32'(bus.trig_out), 0);
        check("rst_valid", 32'(bus.meas_valid), 0);
        check("rst_sel", 32'(bus.sensor_sel), NS - 1);
        check("rst_count", 32'(bus.meas_count), 0);
        check("rst_timeout", 32'(bus.meas_timeout), 0);
        check("rst_msensor", 32'(bus.meas_sensor), 0);

        reset = 1'b1;
        bus.sensor_mask = 4'b0001;
        bus.enable = 1'b1;
        do_ping(K_NORMAL, 20, 30, 1'b0, -1, 4'b1011);

        for (int r = 0; r < 4; r++) begin
            do_ping(K_NORMAL, int'($urandom_range(0, 15)), int'($urandom_range(1, 30)),
                    1'b1, -1, (r == 3) ? 4'b0100 : 4'b1011);
        end

        do_ping(K_NONE, 0, 0, 1'b1, -1, 4'b0001);
        bus.echo_in = 4'b0001;
        do_ping(K_STUCK, 0, 0, 1'b1, -1, 4'b0001);
        do_ping(K_LONG, 8, 0, 1'b1, -1, NS'($urandom_range(1, 15)));

        for (int r = 0; r < 10; r++) begin
            k = kind_t'($urandom_range(0, 2));
            do_ping(k, int'($urandom_range(0, (k == K_LONG) ? 40 : 20)),
                    int'($urandom_range(1, 30)), 1'b1, -1,
                    (r == 9) ? 4'b0001 : NS'($urandom_range(1, 15)));
        end

        do_ping(K_NORMAL, 5, 30, 1'b1, 15, 4'b0001);
        repeat (HO + 3) @(negedge clk);
        check("disable_idle_busy", 32'(bus.busy), 0);
        check("disable_idle_trig", 32'(bus.trig_out), 0);

        bus.enable = 1'b1;
        wt = 0;
        while (bus.trig_out == '0 && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check("trig_before_reset", 32'(bus.trig_out != '0), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_trig", 32'(bus.trig_out), 0);
        check("rst2_busy", 32'(bus.busy), 0);
        check("rst2_valid", 32'(bus.meas_valid), 0);
        check("rst2_sel", 32'(bus.sensor_sel), NS - 1);
        check("rst2_count", 32'(bus.meas_count), 0);
        check("rst2_timeout", 32'(bus.meas_timeout), 0);
        check("rst2_msensor", 32'(bus.meas_sensor), 0);
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
- Round-robin measurement scheduler for up to NUM_SENSORS ultrasonic transducers sharing one echo-timing datapath.
- Sequences each enabled sensor through clear, trigger pulse, echo wait, echo width count, report and inter-ping holdoff.
- Enforces a timeout per ping and a holdoff between pings to suppress cross-talk.
- Sits between the sensor pads (trigger and echo) and the distance-conversion stage that consumes meas_count.

Parameters:
- NUM_SENSORS, 4, number of sensors (2..8).
- SEL_W, 2, width of sensor index; equals clog2(NUM_SENSORS).
- CNT_W, 20, width of the echo and timeout counters.
- TRIG_CYCLES, 200, trigger high time in clk cycles (10 us at 20 MHz).
- TIMEOUT_CYCLES, 760000, maximum cycles from WAIT_ECHO entry to echo fall (38 ms).
- HOLDOFF_CYCLES, 20000, idle cycles between consecutive pings (1 ms).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-low: reset=0 at a rising clk edge resets the block.
- enable, input, 1, run scheduling while high.
- sensor_mask, input, NUM_SENSORS, 1 = sensor participates in the rotation.
- echo_in, input, NUM_SENSORS, raw asynchronous echo lines.
- trig_out, output, NUM_SENSORS, one-hot trigger pulses.
- sensor_sel, output, SEL_W, index of the sensor currently owning the datapath.
- busy, output, 1, high in every state except IDLE.
- meas_valid, output, 1, single-cycle result strobe.
- meas_sensor, output, SEL_W, sensor index of the result; held until the next strobe.
- meas_count, output, CNT_W, echo high width in cycles; held until the next strobe.
- meas_timeout, output, 1, result invalid (no echo, or echo too long); held until the next strobe.

Behaviour:
- Reset: state IDLE. trig_out, busy, meas_valid, meas_timeout = 0. meas_count, meas_sensor = 0. sensor_sel = NUM_SENSORS-1, so the first ping selects the lowest enabled index. Counters and synchronizers cleared.
- Echo lines pass through a 2-flop synchronizer per bit. Only the synchronized echo of sensor_sel is used.
- Round-robin next index: first set bit of sensor_mask strictly after sensor_sel, wrapping. Mask is sampled when leaving IDLE or HOLDOFF.
- States:
  - IDLE: if enable=1 and sensor_mask!=0, latch the next index into sensor_sel and go to CLEAR. Otherwise stay.
  - CLEAR: 1 cycle. Zero the echo and timer counters. Go to TRIG.
  - TRIG: trig_out[sensor_sel]=1 for exactly TRIG_CYCLES cycles. All other trig bits are 0. Go to WAIT_ECHO.
  - WAIT_ECHO: timer increments every cycle. A valid start requires a low-then-high transition of the synced echo; echo already high on entry is not counted until it has been seen low. Valid start goes to MEASURE. If timer reaches TIMEOUT_CYCLES, go to REPORT with timeout=1 and count=0.
  - MEASURE: echo counter increments each cycle the synced echo is high; timer keeps running. On echo low, go to REPORT with timeout=0. If timer reaches TIMEOUT_CYCLES first, go to REPORT with timeout=1 and count = cycles counted so far.
  - REPORT: meas_valid=1 for 1 cycle. meas_sensor, meas_count and meas_timeout update in that same cycle. Go to HOLDOFF.
  - HOLDOFF: wait HOLDOFF_CYCLES. Then if enable=1 and mask!=0, select the next index and go to CLEAR; else go to IDLE.
- meas_count equals the echo pulse width in clk cycles. The synchronizer delay cancels and is not included.
- Counters never wrap. The timer saturates at TIMEOUT_CYCLES, and TIMEOUT_CYCLES < 2^CNT_W.
- A single-bit mask repeats the same sensor. A mask change mid-ping does not abort the ping.
- enable dropping mid-ping: the ping completes, reports and holds off, then goes to IDLE.
- reset=0 in any state: the next edge forces reset values. An in-flight trigger is cut off immediately.
- Echo on non-selected sensors is ignored.

Test Plan:
Benches override parameters to TRIG_CYCLES=4, TIMEOUT_CYCLES=64, HOLDOFF_CYCLES=8, NUM_SENSORS=4, SEL_W=2.
- Basic ping: reset, mask=4'b0001, enable=1, drive echo_in[0] high 20 cycles after trigger falls, for 30 cycles -> trig_out[0] high exactly 4 cycles; one meas_valid with meas_sensor=0, meas_count=30, meas_timeout=0.
- Rotation: mask=4'b1011, echoes on all lines -> result order sensor 0, 1, 3, 0, with ≥8 idle cycles between the REPORT strobe and the next trigger.
- No echo: mask=4'b0100, echo_in held 0 -> meas_valid with meas_sensor=2, meas_timeout=1, meas_count=0, exactly 64 cycles after WAIT_ECHO entry.
- Stuck-high echo: echo_in[0]=1 throughout -> never enters MEASURE; timeout result with count=0.
- Long echo: echo rises at 10 cycles and stays high -> timeout=1, count=54.
- Disable/reset: drop enable during MEASURE -> result still reported, then IDLE with busy=0. Assert reset=0 during TRIG -> trig_out=0 on the next edge and all outputs at reset values.
